// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared types and default parameters for the AGC loop controller
// Purpose : state enumeration and default configuration constants.
// Ports   : none (package).
// Option  : AGC_TIMEOUT_EN enables the FAIL state in agc_loop_ctrl.
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DETECT = 3'd1,
    ST_ADJUST = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } agc_state_t;

  localparam int DEF_DET_W     = 4;
  localparam int DEF_ADJ_W     = 4;
  localparam int DEF_GAIN_W    = 6;
  localparam int DEF_GAIN_INIT = 32;
  localparam int DEF_STEP      = 1;
  localparam int DEF_LOCK_CNT  = 3;
  localparam int DEF_MAX_ADJ   = 15;

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// rtl/agc_loop_ctrl_if.sv - control/status bundle between an AGC loop controller and its user
// Purpose : groups level-detector inputs, control strobes and gain/status outputs.
// Signals : i_start, i_over, i_under, i_abort (into controller);
//           o_gain, o_detect_mode, o_adjust, o_up_dn, o_locked, o_sat, o_fail (out of controller).
// Modports: master = user side, slave = controller side.
interface agc_loop_ctrl_if #(
  parameter int GAIN_W = agc_pkg::DEF_GAIN_W
) ();

  logic              i_start;
  logic              i_over;
  logic              i_under;
  logic              i_abort;
  logic [GAIN_W-1:0] o_gain;
  logic              o_detect_mode;
  logic              o_adjust;
  logic              o_up_dn;
  logic              o_locked;
  logic              o_sat;
  logic              o_fail;

  modport master (
    output i_start, i_over, i_under, i_abort,
    input  o_gain, o_detect_mode, o_adjust, o_up_dn, o_locked, o_sat, o_fail
  );

  modport slave (
    input  i_start, i_over, i_under, i_abort,
    output o_gain, o_detect_mode, o_adjust, o_up_dn, o_locked, o_sat, o_fail
  );

endinterface

// File: rtl/agc_win_counter.sv
// rtl/agc_win_counter.sv - clear/enable up-counter with terminal-count flag
// Purpose : times detect windows and adjust dwell (2^W cycles per wrap).
// Ports   : clk, i_rst (sync active-high), i_clr (sync clear, priority over enable),
//           i_en (count enable), o_tc (high on the enabled cycle where the count is all ones).
module agc_win_counter #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == {W{1'b1}});

endmodule

// File: rtl/agc_loop_ctrl.sv
// rtl/agc_loop_ctrl.sv - automatic gain control acquisition/lock state machine
// Purpose : watches over/under threshold flags per detect window, steps the gain code
//           up or down with saturation, and declares lock after LOCK_CNT clean windows.
// Ports   : clk, RESET (sync active-high), bus (agc_loop_ctrl_if.slave):
//           i_start/i_over/i_under/i_abort in; o_gain/o_sat registered;
//           o_detect_mode/o_adjust/o_up_dn/o_locked/o_fail decoded from state.
// Option  : AGC_TIMEOUT_EN - count ADJUST entries and enter FAIL after MAX_ADJ of them.
module agc_loop_ctrl
  import agc_pkg::*;
#(
  parameter int DET_W     = DEF_DET_W,
  parameter int ADJ_W     = DEF_ADJ_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_INIT = DEF_GAIN_INIT,
  parameter int STEP      = DEF_STEP,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int MAX_ADJ   = DEF_MAX_ADJ
) (
  input  logic            clk,
  input  logic            RESET,
  agc_loop_ctrl_if.slave  bus
);

  localparam int                LC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);
  localparam logic [GAIN_W-1:0] INIT_G = GAIN_W'(GAIN_INIT);

  agc_state_t        r_state, w_next;
  logic              r_over, r_under;
  logic [LC_W-1:0]   r_lock;
  logic [GAIN_W-1:0] r_gain;
  logic              r_sat;
  logic              r_dir;
  logic              r_adj_first;

  logic              w_ovr, w_und;
  logic              w_win_tc, w_adj_tc;
  logic              w_to_adj;
  logic              w_lock_inc;
  logic              w_enter_adj;
  logic [GAIN_W:0]   w_sum;
  logic [GAIN_W-1:0] w_gain_new;
  logic              w_clamp;

  // Window counter runs only in DETECT; leaving DETECT or a restart parks it at zero,
  // so every entry into DETECT starts a fresh window.
  agc_win_counter #(.W(DET_W)) u_win (
    .clk   (clk),
    .i_rst (RESET),
    .i_clr ((r_state != ST_DETECT) || bus.i_start),
    .i_en  (r_state == ST_DETECT),
    .o_tc  (w_win_tc)
  );

  agc_win_counter #(.W(ADJ_W)) u_dwell (
    .clk   (clk),
    .i_rst (RESET),
    .i_clr ((r_state != ST_ADJUST) || bus.i_start),
    .i_en  (r_state == ST_ADJUST),
    .o_tc  (w_adj_tc)
  );

  // Flags including the current cycle, so the last window cycle counts.
  assign w_ovr = r_over  | bus.i_over;
  assign w_und = r_under | bus.i_under;

`ifdef AGC_TIMEOUT_EN
  localparam int AC_W = $clog2(MAX_ADJ + 1);
  logic [AC_W-1:0] r_adj_n;
  logic            w_adj_limit;
  assign w_adj_limit = (r_adj_n == AC_W'(MAX_ADJ));

  always_ff @(posedge clk) begin
    if (RESET || bus.i_start) begin
      r_adj_n <= '0;
    end else if (w_enter_adj) begin
      r_adj_n <= r_adj_n + 1'b1;
    end
  end
`else
  logic w_adj_limit;
  logic w_unused_cfg;
  assign w_adj_limit  = 1'b0;
  assign w_unused_cfg = ^MAX_ADJ;
`endif

  always_comb begin
    w_next     = r_state;
    w_to_adj   = 1'b0;
    w_lock_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) w_next = ST_DETECT;
      end
      ST_DETECT: begin
        if (bus.i_abort) begin
          w_next = ST_LOCKED;
        end else if (bus.i_start) begin
          w_next = ST_DETECT;
        end else if (w_win_tc) begin
          if (w_ovr || w_und) begin
            w_to_adj = 1'b1;
          end else begin
            w_lock_inc = 1'b1;
            if ((int'(r_lock) + 1) >= LOCK_CNT) w_next = ST_LOCKED;
          end
        end
      end
      ST_ADJUST: begin
        if (bus.i_abort) begin
          w_next = ST_LOCKED;
        end else if (bus.i_start || w_adj_tc) begin
          w_next = ST_DETECT;
        end
      end
      ST_LOCKED: begin
        if (bus.i_start) w_next = ST_DETECT;
      end
      ST_FAIL: begin
        if (bus.i_start) w_next = ST_DETECT;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_to_adj) w_next = w_adj_limit ? ST_FAIL : ST_ADJUST;
  end

  assign w_enter_adj = (w_next == ST_ADJUST) && (r_state != ST_ADJUST);

  // Saturating step in the direction latched on ADJUST entry.
  always_comb begin
    w_sum      = {1'b0, r_gain} + {1'b0, STEP_G};
    w_gain_new = r_gain;
    w_clamp    = 1'b0;
    if (r_dir) begin
      if (w_sum[GAIN_W]) begin
        w_gain_new = {GAIN_W{1'b1}};
        w_clamp    = 1'b1;
      end else begin
        w_gain_new = w_sum[GAIN_W-1:0];
      end
    end else begin
      if (r_gain < STEP_G) begin
        w_gain_new = '0;
        w_clamp    = 1'b1;
      end else begin
        w_gain_new = r_gain - STEP_G;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_over      <= 1'b0;
      r_under     <= 1'b0;
      r_lock      <= '0;
      r_gain      <= INIT_G;
      r_sat       <= 1'b0;
      r_dir       <= 1'b1;
      r_adj_first <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_adj_first <= w_enter_adj;

      if ((r_state != ST_DETECT) || bus.i_start || w_win_tc) begin
        r_over  <= 1'b0;
        r_under <= 1'b0;
      end else begin
        r_over  <= w_ovr;
        r_under <= w_und;
      end

      if ((r_state == ST_IDLE) || bus.i_start || w_to_adj) begin
        r_lock <= '0;
      end else if (w_lock_inc) begin
        r_lock <= r_lock + 1'b1;
      end

      // Over wins when both flags were seen: step down.
      if (w_to_adj) r_dir <= ~w_ovr;

      if (bus.i_start) begin
        r_sat <= 1'b0;
      end else if ((r_state == ST_ADJUST) && r_adj_first && !bus.i_abort) begin
        r_gain <= w_gain_new;
        r_sat  <= w_clamp;
      end
    end
  end

  assign bus.o_gain        = r_gain;
  assign bus.o_sat         = r_sat;
  assign bus.o_detect_mode = (r_state == ST_DETECT);
  assign bus.o_adjust      = (r_state == ST_ADJUST);
  assign bus.o_up_dn       = (r_state == ST_ADJUST) ? r_dir : 1'b1;
  assign bus.o_locked      = (r_state == ST_LOCKED);
`ifdef AGC_TIMEOUT_EN
  assign bus.o_fail        = (r_state == ST_FAIL);
`else
  assign bus.o_fail        = 1'b0;
`endif

endmodule
